// File: rtl/div_pkg.sv
// div_pkg: shared state type and width constants for the sequential divider
package div_pkg;
    localparam int DIV_W = 8;
    localparam int DIV_CW = $clog2(DIV_W);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial subtract)
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_rem,
    output logic         o_q
);
    logic [W:0] w_t;
    assign w_t = {i_rem, i_bit};
    assign o_q = w_t >= {1'b0, i_b};
    // the true difference is below B, so dropping the top bit of t is exact
    assign o_rem = o_q ? w_t[W-1:0] - i_b : w_t[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring 2W/W divider, one quotient bit per cycle, valid/ready on both sides
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] C,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   A,
    output logic [W-1:0]   R,
    output logic           ovf,
    output logic           div0
);
    localparam int CW = $clog2(W);
    state_t         r_state, w_next;
    logic [W-1:0]   r_rem, r_dq, r_b, w_rem;
    logic [CW-1:0]  r_cnt;
    logic           w_q, w_acc, w_last, w_err;
    div_step #(.W(W)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dq[W-1]),
        .i_b   (r_b),
        .o_rem (w_rem),
        .o_q   (w_q)
    );
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign w_acc     = in_valid && in_ready;
    assign w_last    = r_cnt == CW'(W - 1);
    assign w_err     = B == '0 || C[2*W-1:W] >= B;
    always_comb begin
        w_next = r_state;
        if (w_acc)
            w_next = w_err ? DONE : RUN;
        else if (r_state == RUN)
            w_next = w_last ? DONE : RUN;
        else if (r_state == DONE)
            w_next = out_ready ? IDLE : DONE;
    end
    // dq doubles as the quotient register: dividend bits leave the top, quotient bits enter the bottom
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_dq    <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            A       <= '0;
            R       <= '0;
            ovf     <= 1'b0;
            div0    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_b   <= B;
                r_rem <= C[2*W-1:W];
                r_dq  <= C[W-1:0];
                r_cnt <= '0;
                if (w_err) begin
                    A    <= '1;
                    R    <= B == '0 ? C[W-1:0] : '0;
                    div0 <= B == '0;
                    ovf  <= B != '0;
                end
            end else if (r_state == RUN) begin
                r_rem <= w_rem;
                r_dq  <= {r_dq[W-2:0], w_q};
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    A    <= {r_dq[W-2:0], w_q};
                    R    <= w_rem;
                    ovf  <= 1'b0;
                    div0 <= 1'b0;
                end
            end
        end
    end
endmodule
